// File: rtl/an_residue_serial.sv
// an_residue_serial: bit-serial residue of an AN-coded word modulo A, MSB first,
// one conditional subtraction per bit, result presented on a valid/ready handshake.
module an_residue_serial #(
    parameter int A  = 13837,
    parameter int CW = 38,
    parameter int RW = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_cw,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_r,
    output logic          out_zero,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam int CNTW = $clog2(CW);
    localparam logic [RW:0] A_W = (RW+1)'(A);
    state_t state_q, state_d;
    logic [CW-1:0] shreg_q, shreg_d;
    logic [RW-1:0] acc_q, acc_d, out_r_q, out_r_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic out_zero_q, out_zero_d, busy_q, busy_d;
    logic [RW:0] t, t_sub;
    always_comb begin
        t = {acc_q, shreg_q[CW-1]};
        t_sub = t - A_W;
        state_d = state_q;
        shreg_d = shreg_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        in_ready_d = in_ready_q;
        out_valid_d = out_valid_q;
        out_r_d = out_r_q;
        out_zero_d = out_zero_q;
        busy_d = busy_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = CALC;
                shreg_d = in_cw;
                acc_d = '0;
                cnt_d = CNTW'(CW - 1);
                in_ready_d = 1'b0;
                busy_d = 1'b1;
            end
            CALC: begin
                // acc < A keeps t below 2A, so one subtraction fully reduces it
                acc_d = (t >= A_W) ? t_sub[RW-1:0] : t[RW-1:0];
                shreg_d = {shreg_q[CW-2:0], 1'b0};
                cnt_d = cnt_q - CNTW'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    busy_d = 1'b0;
                    out_valid_d = 1'b1;
                    out_r_d = acc_d;
                    out_zero_d = (acc_d == '0);
                end
            end
            DONE: if (out_ready) begin
                state_d = IDLE;
                out_valid_d = 1'b0;
                out_r_d = '0;
                out_zero_d = 1'b0;
                in_ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            in_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
            out_r_q <= '0;
            out_zero_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            in_ready_q <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_r_q <= out_r_d;
            out_zero_q <= out_zero_d;
            busy_q <= busy_d;
        end
    end
    assign in_ready = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_r = out_r_q;
    assign out_zero = out_zero_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_an_residue_serial.sv
// tb_an_residue_serial: directed and random checks of the serial AN residue unit.
module tb_an_residue_serial;
    localparam int A = 13837;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [37:0] in_cw = '0;
    logic in_ready, out_valid, out_zero, busy;
    logic [13:0] out_r;
    int total = 0, passed = 0;
    logic acc_bad = 1'b0;

    an_residue_serial dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_cw(in_cw), .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_zero(out_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (busy && dut.acc_q >= 14'(A)) acc_bad = 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [37:0] cw);
        int n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
        check("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_cw = cw;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        check({tag, "_latency"}, 64'(n), 64'd38);
    endtask

    task automatic run_cw(input string tag, input logic [37:0] cw, input int stall);
        logic [63:0] exp;
        exp = {26'd0, cw} % 64'(A);
        accept(cw);
        wait_result(tag);
        check({tag, "_r"}, {50'd0, out_r}, exp);
        check({tag, "_zero"}, {63'd0, out_zero}, {63'd0, exp == 0});
        repeat (stall) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_ready_back"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_r", {50'd0, out_r}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);

        run_cw("clean_a", 38'd13837, 0);
        run_cw("clean_0", 38'd0, 1);
        run_cw("plus1", 38'd13838, 0);
        run_cw("minus1", 38'd13836, 2);
        run_cw("bit14", 38'd16384, 0);
        run_cw("five_a_bit12", 38'd73281, 0);
        run_cw("all_ones", 38'h3F_FFFF_FFFF, 0);
        check("bit14_value", 64'd16384 % 64'(A), 64'd2547);

        // backpressure: result must hold and new codewords must be ignored
        accept(38'd13838);
        check("bp_busy", {63'd0, busy}, 64'd1);
        wait_result("bp");
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_cw = 38'(i * 7919 + 5);
            tick();
            check("bp_out_r", {50'd0, out_r}, 64'd1);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_ready", {63'd0, in_ready}, 64'd1);
        check("bp_release_valid", {63'd0, out_valid}, 64'd0);
        tick();
        check("bp_no_accept", {63'd0, busy}, 64'd0);

        // asynchronous reset in the middle of CALC
        accept(38'd13837);
        repeat (19) tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_out_r", {50'd0, out_r}, 64'd0);
        #1 rst_n = 1'b1;
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 45; i++) begin
                tick();
                if (out_valid) seen = 1'b1;
            end
            check("mid_rst_no_output", {63'd0, seen}, 64'd0);
        end
        run_cw("after_rst", 38'd13838, 0);

        for (int i = 0; i < 200; i++) begin
            logic [63:0] r;
            r = {$urandom(), $urandom()};
            run_cw("rand", r[37:0], int'($urandom_range(0, 3)));
        end
        check("acc_below_a", {63'd0, acc_bad}, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
